// File: rtl/if_stage_pkg.sv
// Shared MIPS front-end definitions: PC source encodings, instruction field
// positions and fetch-stage constants.
package if_stage_pkg;

   typedef enum logic [2:0] {
      PC_NEXT = 3'd0,
      PC_JUMP = 3'd1,
      PC_JR   = 3'd2,
      PC_BEQ  = 3'd3
   } pc_src_e;

   localparam logic [4:0] GPR_RA           = 5'd31;
   localparam int         INST_J_INDEX_MSB = 25;
   localparam int         INST_IMM_MSB     = 15;

   localparam int FETCH_STEP       = 4;
   localparam int FETCH_REGION_LSB = 28;

   // Width able to hold 0..depth inclusive (FIFO count, outstanding, drop).
   function automatic int fetch_credit_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction memory handshake, decode hand-off and
// redirect request. master = fetch stage, slave = memory/decode side.
interface if_stage_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  inst_ren;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_ack;
   logic                  inst_rvalid;
   logic [INST_WIDTH-1:0] inst_data;

   logic                  id_valid;
   logic [INST_WIDTH-1:0] id_inst;
   logic [ADDR_WIDTH-1:0] id_pc;
   logic                  id_ready;

   logic                  redir_en;
   logic [2:0]            redir_src;
   logic [ADDR_WIDTH-1:0] redir_pc;
   logic [INST_WIDTH-1:0] redir_inst;
   logic [ADDR_WIDTH-1:0] redir_rs;
   logic                  redir_taken;

   modport master (
      output inst_ren, inst_addr, id_valid, id_inst, id_pc,
      input  inst_ack, inst_rvalid, inst_data, id_ready,
      input  redir_en, redir_src, redir_pc, redir_inst, redir_rs, redir_taken
   );

   modport slave (
      input  inst_ren, inst_addr, id_valid, id_inst, id_pc,
      output inst_ack, inst_rvalid, inst_data, id_ready,
      output redir_en, redir_src, redir_pc, redir_inst, redir_rs, redir_taken
   );
endinterface

// File: rtl/if_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the register
// array so it is valid the cycle after the push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   // A pop frees the slot, so push into a full FIFO is fine when paired with a pop.
   assign do_push = push_i & ~flush_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~flush_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q + PW'(do_push);
      rd_d  = rd_q + PW'(do_pop);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_ni)
      !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited memory requests,
// buffers {instruction, PC} for decode and handles redirects from decode.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    INST_WIDTH   = 32,
   parameter int                    BUF_DEPTH    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic        clk,
   input  logic        cpu_rst_n,
   input  logic        cpu_en,
   if_stage_if.master  bus
);
   localparam int CW = fetch_credit_w(BUF_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         out_q, out_d, drop_q, drop_d;
   logic [CW-1:0]         buf_count, aq_count;
   logic [CW:0]           credit_used;
   logic                  buf_empty, buf_full, aq_empty, aq_full;
   logic                  inst_ren_w, id_valid_w, req_fire, resp_keep;
   logic                  redir_take, redir_eff;
   logic [ADDR_WIDTH-1:0] resp_pc, pc_plus4, br_offset, redir_target;
   logic                  unused_bits;

   // Credits cover both buffered entries and requests still in flight.
   assign credit_used = {1'b0, buf_count} + {1'b0, out_q};
   assign inst_ren_w  = cpu_rst_n & cpu_en & ~bus.redir_en & (credit_used < (CW+1)'(BUF_DEPTH));
   assign req_fire    = inst_ren_w & bus.inst_ack;
   assign resp_keep   = bus.inst_rvalid & (drop_q == '0);
   assign id_valid_w  = cpu_en & ~buf_empty;

   assign bus.inst_ren  = inst_ren_w;
   assign bus.inst_addr = pc_q;
   assign bus.id_valid  = id_valid_w;

   assign pc_plus4  = bus.redir_pc + ADDR_WIDTH'(FETCH_STEP);
   assign br_offset = {{(ADDR_WIDTH-18){bus.redir_inst[INST_IMM_MSB]}},
                       bus.redir_inst[INST_IMM_MSB:0], 2'b00};

   always_comb begin
      redir_take   = 1'b0;
      redir_target = bus.redir_rs;
      case (pc_src_e'(bus.redir_src))
         PC_JUMP: begin
            redir_take   = 1'b1;
            redir_target = {pc_plus4[ADDR_WIDTH-1:FETCH_REGION_LSB],
                            bus.redir_inst[INST_J_INDEX_MSB:0], 2'b00};
         end
         PC_JR: begin
            redir_take   = 1'b1;
            redir_target = bus.redir_rs;
         end
         PC_BEQ: begin
            redir_take   = bus.redir_taken;
            redir_target = pc_plus4 + br_offset;
         end
         default: redir_take = 1'b0;
      endcase
   end

   assign redir_eff = cpu_en & bus.redir_en & redir_take;

   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q + CW'(req_fire) - CW'(bus.inst_rvalid);
      drop_d = drop_q;
      if (bus.inst_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      // Everything still in flight after this cycle belongs to the old path.
      if (redir_eff) begin
         pc_d   = redir_target;
         drop_d = out_q - CW'(bus.inst_rvalid);
      end else if (req_fire) begin
         pc_d = pc_q + ADDR_WIDTH'(FETCH_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (!cpu_rst_n) begin
         pc_q   <= RESET_VECTOR;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(BUF_DEPTH)) u_addr_q (
      .clk     (clk),
      .rst_ni  (cpu_rst_n),
      .push_i  (req_fire),
      .pop_i   (resp_keep),
      .flush_i (redir_eff),
      .wdata_i (pc_q),
      .rdata_o (resp_pc),
      .full_o  (aq_full),
      .empty_o (aq_empty),
      .count_o (aq_count)
   );

   sync_fifo #(.WIDTH(INST_WIDTH + ADDR_WIDTH), .DEPTH(BUF_DEPTH)) u_inst_buf (
      .clk     (clk),
      .rst_ni  (cpu_rst_n),
      .push_i  (resp_keep & ~redir_eff),
      .pop_i   (id_valid_w & bus.id_ready),
      .flush_i (redir_eff),
      .wdata_i ({bus.inst_data, resp_pc}),
      .rdata_o ({bus.id_inst, bus.id_pc}),
      .full_o  (buf_full),
      .empty_o (buf_empty),
      .count_o (buf_count)
   );

   assign unused_bits = ^{aq_full, aq_empty, aq_count, buf_full,
                          bus.redir_inst[INST_WIDTH-1:INST_J_INDEX_MSB+1]};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch/stall table plus hand-written
// redirect, enable and reset sequences against a fixed-latency memory model.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int AW = 32;
   localparam int IW = 32;

   logic clk = 1'b0;
   logic cpu_rst_n;
   logic cpu_en;

   always #5 clk = ~clk;

   if_stage_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

   if_stage #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .BUF_DEPTH(4), .RESET_VECTOR(32'h0)) dut (
      .clk       (clk),
      .cpu_rst_n (cpu_rst_n),
      .cpu_en    (cpu_en),
      .bus       (bus)
   );

   typedef struct {
      logic        rdy;
      logic        ren;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t        tbl [16];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          due_q[$];
   logic [31:0] addr_q[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a * 32'd3 + 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // One clock: capture this cycle's request, advance, then present due responses.
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      fire = bus.inst_ren & bus.inst_ack;
      a    = bus.inst_addr;
      @(posedge clk);
      cyc++;
      if (fire === 1'b1 && cpu_rst_n === 1'b1) begin
         due_q.push_back(cyc - 1 + mem_lat);
         addr_q.push_back(a);
      end
      #1;
      bus.inst_rvalid = 1'b0;
      bus.inst_data   = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         bus.inst_rvalid = 1'b1;
         bus.inst_data   = memf(addr_q[0]);
         void'(due_q.pop_front());
         void'(addr_q.pop_front());
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         #1;
         tick();
      end
   endtask

   task automatic do_reset(input int lat);
      cpu_rst_n       = 1'b0;
      cpu_en          = 1'b1;
      bus.inst_ack    = 1'b1;
      bus.id_ready    = 1'b1;
      bus.redir_en    = 1'b0;
      bus.redir_taken = 1'b0;
      mem_lat         = lat;
      due_q.delete();
      addr_q.delete();
      tick();
      tick();
      #1;
      chk("rst_ren", {31'b0, bus.inst_ren}, 32'h0);
      chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
      chk("rst_addr", bus.inst_addr, 32'h0);
      cpu_rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [2:0] src, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [31:0] rs, input logic taken);
      bus.redir_en    = 1'b1;
      bus.redir_src   = src;
      bus.redir_pc    = pc;
      bus.redir_inst  = inst;
      bus.redir_rs    = rs;
      bus.redir_taken = taken;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.inst_rvalid = 1'b0;
      bus.inst_data   = '0;
      bus.inst_ack    = 1'b0;
      bus.id_ready    = 1'b0;
      bus.redir_en    = 1'b0;
      bus.redir_src   = 3'd0;
      bus.redir_pc    = '0;
      bus.redir_inst  = '0;
      bus.redir_rs    = '0;
      bus.redir_taken = 1'b0;
      cpu_rst_n       = 1'b0;
      cpu_en          = 1'b1;

      //             rdy   ren   addr        valid pc
      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
      tbl[5]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04};
      tbl[6]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04};
      tbl[7]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04};
      tbl[8]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h04};
      tbl[9]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
      tbl[10] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
      tbl[11] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
      tbl[12] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
      tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
      tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
      tbl[15] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

      // Sequential fetch, then decode stall filling the buffer, then drain.
      do_reset(1);
      for (int i = 0; i < 16; i++) begin
         bus.id_ready = tbl[i].rdy;
         #1;
         chk($sformatf("seq%0d_ren", i), {31'b0, bus.inst_ren}, {31'b0, tbl[i].ren});
         chk($sformatf("seq%0d_addr", i), bus.inst_addr, tbl[i].addr);
         chk($sformatf("seq%0d_valid", i), {31'b0, bus.id_valid}, {31'b0, tbl[i].valid});
         if (tbl[i].valid) begin
            chk($sformatf("seq%0d_pc", i), bus.id_pc, tbl[i].pc);
            chk($sformatf("seq%0d_inst", i), bus.id_inst, memf(tbl[i].pc));
         end
         tick();
      end

      // Taken BEQ with two fetches in flight (latency 3): both are dropped.
      do_reset(3);
      idle(2);
      bus.inst_ack = 1'b0;
      redirect(PC_BEQ, 32'h40, 32'h1000_FFFE, 32'h0, 1'b1);
      #1;
      chk("beq_ren_blocked", {31'b0, bus.inst_ren}, 32'h0);
      tick();
      bus.redir_en = 1'b0;
      bus.inst_ack = 1'b1;
      #1;
      chk("beq_target", bus.inst_addr, 32'h3C);
      chk("beq_ren", {31'b0, bus.inst_ren}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("beq_drop_valid%0d", k), {31'b0, bus.id_valid}, 32'h0);
         tick();
         #1;
      end
      chk("beq_first_valid", {31'b0, bus.id_valid}, 32'h1);
      chk("beq_first_pc", bus.id_pc, 32'h3C);
      chk("beq_first_inst", bus.id_inst, memf(32'h3C));
      tick();
      #1;
      chk("beq_second_pc", bus.id_pc, 32'h40);

      // Not-taken BEQ: nothing flushed, sequential fetch continues.
      do_reset(1);
      idle(2);
      redirect(PC_BEQ, 32'h40, 32'h1000_FFFE, 32'h0, 1'b0);
      #1;
      chk("bnt_ren", {31'b0, bus.inst_ren}, 32'h0);
      tick();
      bus.redir_en = 1'b0;
      #1;
      chk("bnt_valid", {31'b0, bus.id_valid}, 32'h1);
      chk("bnt_pc", bus.id_pc, 32'h04);
      chk("bnt_addr", bus.inst_addr, 32'h08);

      // J followed by JR.
      do_reset(1);
      idle(1);
      redirect(PC_JUMP, 32'h1000_0010, 32'h0800_0100, 32'h0, 1'b0);
      #1;
      chk("j_ren", {31'b0, bus.inst_ren}, 32'h0);
      tick();
      bus.redir_en = 1'b0;
      #1;
      chk("j_target", bus.inst_addr, 32'h1000_0400);
      chk("j_valid0", {31'b0, bus.id_valid}, 32'h0);
      tick();
      #1;
      chk("j_valid1", {31'b0, bus.id_valid}, 32'h0);
      tick();
      redirect(PC_JR, 32'h1000_0404, 32'h03E0_0008, 32'h80, 1'b0);
      #1;
      chk("j_pc", bus.id_pc, 32'h1000_0400);
      chk("j_inst", bus.id_inst, memf(32'h1000_0400));
      tick();
      bus.redir_en = 1'b0;
      #1;
      chk("jr_target", bus.inst_addr, 32'h80);
      chk("jr_valid0", {31'b0, bus.id_valid}, 32'h0);
      tick();
      #1;
      chk("jr_valid1", {31'b0, bus.id_valid}, 32'h0);
      tick();
      #1;
      chk("jr_pc", bus.id_pc, 32'h80);

      // cpu_en low for 5 cycles while a response arrives.
      do_reset(1);
      idle(1);
      cpu_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("en_addr%0d", k), bus.inst_addr, 32'h04);
         chk($sformatf("en_valid%0d", k), {31'b0, bus.id_valid}, 32'h0);
         chk($sformatf("en_ren%0d", k), {31'b0, bus.inst_ren}, 32'h0);
         tick();
      end
      cpu_en = 1'b1;
      #1;
      chk("en_valid", {31'b0, bus.id_valid}, 32'h1);
      chk("en_pc", bus.id_pc, 32'h0);
      chk("en_inst", bus.id_inst, memf(32'h0));
      chk("en_addr", bus.inst_addr, 32'h04);

      // Redirect together with push and pop (3 buffered, 1 arriving).
      do_reset(1);
      bus.id_ready = 1'b0;
      idle(4);
      bus.id_ready = 1'b1;
      redirect(PC_JR, 32'h0, 32'h0, 32'h200, 1'b0);
      #1;
      chk("rpp_valid", {31'b0, bus.id_valid}, 32'h1);
      chk("rpp_rvalid_pc", bus.id_pc, 32'h0);
      tick();
      bus.redir_en = 1'b0;
      #1;
      chk("rpp_flushed", {31'b0, bus.id_valid}, 32'h0);
      chk("rpp_target", bus.inst_addr, 32'h200);
      tick();
      #1;
      tick();
      #1;
      chk("rpp_pc", bus.id_pc, 32'h200);

      // Redirect with a full buffer and a pop.
      do_reset(1);
      bus.id_ready = 1'b0;
      idle(5);
      #1;
      chk("full_ren", {31'b0, bus.inst_ren}, 32'h0);
      bus.id_ready = 1'b1;
      redirect(PC_JUMP, 32'h0000_0100, 32'h0800_0040, 32'h0, 1'b0);
      tick();
      bus.redir_en = 1'b0;
      #1;
      chk("full_flushed", {31'b0, bus.id_valid}, 32'h0);
      chk("full_target", bus.inst_addr, 32'h100);
      tick();
      #1;
      tick();
      #1;
      chk("full_pc", bus.id_pc, 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
